// File: rtl/md_pkg.sv
// Shared definitions for the motion-update broadcast arbiter.
// Holds the phase FSM encodings, the default settle length and a pointer helper.
// No logic of its own; imported by the arbiter top.
package md_pkg;

  typedef enum logic [1:0] {
    MU_IDLE   = 2'd0,
    MU_BCAST  = 2'd1,
    MU_SETTLE = 2'd2,
    MU_DONE   = 2'd3
  } mu_state_t;

  // Three idle cycles cover the cache sequence WRITE_PARTICLE_NUM -> MOTION_UPDATE_DONE -> WAIT.
  localparam int SETTLE_CYCLES_DEFAULT = 3;

  // Next round-robin start position after index idx, wrapping at n.
  function automatic int rr_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mu_bcast_arbiter_if.sv
// Requester-side and broadcast-side bus of the motion-update arbiter.
// master: the arbiter (consumes requests, drives grants and broadcast).
// slave: the surrounding environment (drives requests, observes broadcast).
interface mu_bcast_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int CELL_ID_WIDTH = 4,
  parameter int NUM_REQ       = 4
);
  logic [NUM_REQ-1:0]                 in_req_valid;
  logic [NUM_REQ-1:0]                 in_req_done;
  logic [NUM_REQ*3*DATA_WIDTH-1:0]    in_req_data;
  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0] in_req_dst_cell;
  logic [NUM_REQ-1:0]                 out_req_ready;
  logic [3*DATA_WIDTH-1:0]            out_data;
  logic [3*CELL_ID_WIDTH-1:0]         out_dst_cell;
  logic                               out_data_valid;

  modport master (
    input  in_req_valid, in_req_done, in_req_data, in_req_dst_cell,
    output out_req_ready, out_data, out_dst_cell, out_data_valid
  );

  modport slave (
    output in_req_valid, in_req_done, in_req_data, in_req_dst_cell,
    input  out_req_ready, out_data, out_dst_cell, out_data_valid
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, with wrap-around.
// Latency: purely combinational, grant and index valid in the same cycle.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 any
);

  logic [IDX_WIDTH:0]   pos;
  logic [IDX_WIDTH-1:0] cand;

  // Walk the requesters starting at ptr and latch the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + (IDX_WIDTH+1)'(k);
      if (pos >= (IDX_WIDTH+1)'(NUM_REQ)) begin
        pos = pos - (IDX_WIDTH+1)'(NUM_REQ);
      end
      cand = pos[IDX_WIDTH-1:0];
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/mu_bcast_arbiter.sv
// Motion-update broadcast arbiter and phase sequencer; optional grant counter under MU_ARB_BCAST_COUNT_EN.
// Latency: grant to registered broadcast 1 cycle; enable falls 1 cycle after all-done, done pulse SETTLE_CYCLES later.
// Backpressure: one-hot combinational ready; a requester waits (valid held) until it wins round-robin.
module mu_bcast_arbiter
  import md_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int CELL_ID_WIDTH = 4,
  parameter int NUM_REQ       = 4,
  parameter int REQ_ID_WIDTH  = 2,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_phase_start,
  mu_bcast_arbiter_if.master bus,
  output logic               motion_update_enable,
  output logic               out_phase_done,
  output logic               out_busy
`ifdef MU_ARB_BCAST_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] out_bcast_count
`endif
);

  localparam int SCW = $clog2(SETTLE_CYCLES + 1);

  if (NUM_REQ < 2 || (1 << REQ_ID_WIDTH) < NUM_REQ || SETTLE_CYCLES < 1 || COUNT_WIDTH < 1) begin : g_bad_params
    $error("mu_bcast_arbiter: illegal parameter combination");
  end

  mu_state_t               state;
  logic [REQ_ID_WIDTH-1:0] rr_ptr;
  logic [SCW-1:0]          settle_cnt;
  logic [NUM_REQ-1:0]      eligible;
  logic [NUM_REQ-1:0]      grant;
  logic [REQ_ID_WIDTH-1:0] win;
  logic                    any;
  logic                    all_done;

  logic [3*DATA_WIDTH-1:0]    req_data_arr [NUM_REQ];
  logic [3*CELL_ID_WIDTH-1:0] req_dst_arr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data_arr[i] = bus.in_req_data[i*3*DATA_WIDTH +: 3*DATA_WIDTH];
    assign req_dst_arr[i]  = bus.in_req_dst_cell[i*3*CELL_ID_WIDTH +: 3*CELL_ID_WIDTH];
  end

  // A requester that has declared done is never eligible, even if its valid is stuck high.
  assign eligible = bus.in_req_valid & ~bus.in_req_done;
  assign all_done = &bus.in_req_done;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .IDX_WIDTH(REQ_ID_WIDTH)
  ) u_rr (
    .req  (eligible),
    .ptr  (rr_ptr),
    .grant(grant),
    .idx  (win),
    .any  (any)
  );

  // Grants only exist while broadcasting, so every transfer lands inside the enable window.
  assign bus.out_req_ready = (state == MU_BCAST) ? grant : '0;

  // Phase FSM with registered enable, broadcast bus, busy and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= MU_IDLE;
      rr_ptr               <= '0;
      settle_cnt           <= '0;
      motion_update_enable <= 1'b0;
      out_phase_done       <= 1'b0;
      out_busy             <= 1'b0;
      bus.out_data_valid   <= 1'b0;
      bus.out_data         <= '0;
      bus.out_dst_cell     <= '0;
    end else begin
      bus.out_data_valid <= 1'b0;
      bus.out_data       <= '0;
      bus.out_dst_cell   <= '0;
      out_phase_done     <= 1'b0;
      case (state)
        MU_IDLE: begin
          if (in_phase_start) begin
            state                <= MU_BCAST;
            motion_update_enable <= 1'b1;
            out_busy             <= 1'b1;
          end
        end
        MU_BCAST: begin
          if (any) begin
            bus.out_data_valid <= 1'b1;
            bus.out_data       <= req_data_arr[win];
            bus.out_dst_cell   <= req_dst_arr[win];
            rr_ptr             <= REQ_ID_WIDTH'(rr_wrap_inc(int'(win), NUM_REQ));
          end
          if (all_done) begin
            state                <= MU_SETTLE;
            motion_update_enable <= 1'b0;
            settle_cnt           <= '0;
          end
        end
        MU_SETTLE: begin
          if (settle_cnt == SCW'(SETTLE_CYCLES - 1)) begin
            state          <= MU_DONE;
            out_phase_done <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SCW'(1);
          end
        end
        MU_DONE: begin
          state    <= MU_IDLE;
          out_busy <= 1'b0;
        end
        default: begin
          state    <= MU_IDLE;
          out_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef MU_ARB_BCAST_COUNT_EN
  // Per-phase broadcast count: cleared on an accepted start, saturating, held after the phase ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_bcast_count <= '0;
    end else if (state == MU_IDLE && in_phase_start) begin
      out_bcast_count <= '0;
    end else if (state == MU_BCAST && any && !(&out_bcast_count)) begin
      out_bcast_count <= out_bcast_count + 1'b1;
    end
  end
`endif

endmodule
